// File: rtl/cdc_hs_src.sv
// -----------------------------------------------------------------------------
// cdc_hs_src
//
// Source end of a req/ack clock-domain-crossing handshake. A word offered on
// the local valid/ready port is captured into data_o, and the far domain is
// told about it through req_o. The transfer completes only after the far
// domain's acknowledge has been synchronized into clk_i and has closed the
// protocol. The word on data_o is held stable for the whole transfer, so the
// far side may sample it at any point after it has seen the request.
//
// Build option:
//   CDC_HS_SRC_TWO_PHASE_EN  undefined: four-phase (return-to-zero) protocol
//                            defined:   two-phase (toggle) protocol
//
// Parameters:
//   DATA_WIDTH   width of the transferred word
//   SYNC_STAGES  flops in the ack_i synchronizer (>= 2)
//
// Ports:
//   clk_i     source-domain clock
//   rst_ni    asynchronous active-low reset
//   valid_i   a word is offered on data_i
//   ready_o   the block accepts a word on this edge if valid_i is high
//   data_i    word to send
//   req_o     request to the far domain, straight from a flop
//   data_o    held word, registered
//   ack_i     acknowledge from the far domain, asynchronous to clk_i
//   busy_o    a transfer is in flight
//   done_o    one-cycle pulse when a transfer completes
//
// Handshake: a word moves on a rising clk_i edge where valid_i && ready_o.
// ready_o depends only on the FSM state and the synchronized ack, never on
// valid_i. A source that sees ready_o low keeps valid_i and data_i steady
// until the word is taken.
// -----------------------------------------------------------------------------
module cdc_hs_src #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_i,
  output logic                  busy_o,
  output logic                  done_o
);

  // A single-flop "synchronizer" cannot settle metastability, so refuse to
  // build with fewer than two stages.
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("cdc_hs_src: SYNC_STAGES must be at least 2");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM encoding. state_q is the observable state register.
  // ---------------------------------------------------------------------------
`ifdef CDC_HS_SRC_TWO_PHASE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACKW = 2'd2
  } state_e;
`endif

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SYNC_STAGES-1:0]  ack_sync_q, ack_sync_d;
  logic                    ack_sync;
  logic                    accept;

  // ---------------------------------------------------------------------------
  // ack_i synchronizer: bit 0 samples the asynchronous input, the last bit is
  // the only one the FSM is allowed to look at.
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_i};
  end

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Ready / accept.
  // ---------------------------------------------------------------------------
`ifdef CDC_HS_SRC_TWO_PHASE_EN
  // Reset levels of req_q and the ack chain are both 0, so IDLE always means
  // the previous toggle has been answered.
  assign ready_o = (state_q == ST_IDLE);
`else
  // In four-phase mode an ack still high in IDLE (stale after reset, or a slow
  // far side still returning to zero) must block the next request, otherwise
  // the far side could miss the rising edge of req_o.
  assign ready_o = (state_q == ST_IDLE) && !ack_sync;
`endif

  assign accept = valid_i && ready_o;

  // ---------------------------------------------------------------------------
  // Next-state and output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    busy_d  = busy_q;
    data_d  = data_q;
    done_d  = 1'b0;

    unique case (state_q)
`ifdef CDC_HS_SRC_TWO_PHASE_EN
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          req_d   = ~req_q;
          busy_d  = 1'b1;
          data_d  = data_i;
        end
      end

      // The far side answers by making its ack level equal to req.
      ST_WAIT: begin
        if (ack_sync == req_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`else
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          data_d  = data_i;
        end
      end

      // Far side has seen the request and sampled data_o: drop req.
      ST_REQ: begin
        if (ack_sync) begin
          state_d = ST_ACKW;
          req_d   = 1'b0;
        end
      end

      // Wait for the far side to return ack to zero before completing, so
      // the next request starts from a clean low/low state.
      ST_ACKW: begin
        if (!ack_sync) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset drops any in-flight word; the far side is expected to be
  // reset together with this block.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_q     <= data_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  assign req_o  = req_q;
  assign data_o = data_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: doc/cdc_hs_src.md
# cdc_hs_src

Source end of a req/ack clock-domain-crossing handshake. It accepts one word at a time on a valid/ready port in its own clock domain. It holds the word stable on `data_o` and signals the far domain on `req_o`. It completes the transfer only after the far domain's asynchronous `ack_i`, synchronized internally, closes the protocol. It pairs with a destination-side block that synchronizes `req_o` and samples `data_o` once the request is seen.

## Interface
- `DATA_WIDTH`, default 32: width of the transferred word.
- `SYNC_STAGES`, default 2: flip-flop stages on `ack_i`. Must be ≥ 2; elaboration fails otherwise.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_i`, in, 1: source-domain clock.
  - `rst_ni`, in, 1: async active-low reset.
- Source-side port:
  - `valid_i`, in, 1: word offered.
  - `ready_o`, out, 1: block can accept a word.
  - `data_i`, in, `DATA_WIDTH`: word to send.
- Far-domain handshake:
  - `req_o`, out, 1: request to the far domain. Driven directly from a flop; no glitches.
  - `data_o`, out, `DATA_WIDTH`: held word, registered.
  - `ack_i`, in, 1: acknowledge from the far domain, asynchronous to `clk_i`.
- Status:
  - `busy_o`, out, 1: a transfer is in flight.
  - `done_o`, out, 1: one-cycle pulse when a transfer completes.

## Operation
- Internal `ack_sync` is the last stage of a `SYNC_STAGES`-deep flop chain sampling `ack_i`. All chain flops reset to 0.
- A word is accepted on a rising edge where `valid_i && ready_o`. On that same edge:
  - `data_o` <= `data_i`.
  - `req_o` asserts.
  - `busy_o` <= 1.
- `data_o` holds from acceptance until `done_o`; it never changes while `busy_o` = 1.

Four-phase FSM (default build):
- **IDLE**:
  - `req_o` = 0, `busy_o` = 0.
  - `ready_o` = (`ack_sync` == 0). This guards against a stale high ack after reset or a slow far side.
  - On accept, go to REQ.
- **REQ**:
  - `req_o` = 1, `ready_o` = 0.
  - When `ack_sync` == 1, set `req_o` <= 0 and go to ACKW.
- **ACKW**:
  - `req_o` = 0, `ready_o` = 0.
  - When `ack_sync` == 0, set `done_o` <= 1 for one cycle, `busy_o` <= 0, and go to IDLE.

Other rules:
- `ready_o` is combinational from state and `ack_sync` only; it does not depend on `valid_i`.
- `valid_i` while busy is ignored. The word is not consumed; the source keeps it asserted.
- `valid_i` may be high on the same edge that `done_o` is registered. It is not accepted on that edge, because the FSM is still in ACKW. It is accepted on the next edge if still present.
- Async reset mid-transfer immediately forces all outputs to reset values and drops the in-flight word. The far-side block must be reset together with this one.
- Reset values:
  - `req_o` = 0, `data_o` = 0, `busy_o` = 0, `done_o` = 0.
  - FSM = IDLE.
  - `ready_o` = 1 once the ack synchronizer chain is 0, which it is after reset.

## Timing
- Accept edge `e0`: `req_o`, `data_o` and `busy_o` are valid after `e0`.
- If `ack_i` is first sampled high at edge `n`:
  - `ack_sync` goes high after edge `n+SYNC_STAGES-1`.
  - `req_o` falls after edge `n+SYNC_STAGES`.
- If `ack_i` is first sampled low at edge `m`:
  - `done_o` is high for the cycle after edge `m+SYNC_STAGES`.
  - `ready_o` is 1 from that same cycle.
- Minimum 4-phase round trip with an ideal far side, from accept to next possible accept: 2·(`SYNC_STAGES`+1) + 2 far-side synchronizer latencies.
- `data_o` changes only on an accept edge.

## Configuration
- Macro: `CDC_HS_SRC_TWO_PHASE_EN`.
- **Undefined**: four-phase protocol as described under Operation.
- **Defined**: two-phase (toggle) protocol with states IDLE and WAIT.
  - An accept toggles `req_o` (`req_o` <= ~`req_o`) and moves to WAIT.
  - WAIT exits when `ack_sync` == `req_o`. The exit pulses `done_o` and returns to IDLE.
  - `ready_o` = IDLE. There is no `ack_sync` guard, since the reset levels of `req_o` and `ack_sync` match.
  - Round trip is halved.
  - Interface and reset values are unchanged.

## Test plan
- **Reset mid-transfer.** Reset; accept `0xDEADBEEF`. Then assert `rst_ni` low while in REQ. Required:
  - After reset: `ready_o` = 1, `req_o` = 0, `data_o` = 0.
  - After the accept: `req_o` = 1 and `data_o` = `0xDEADBEEF` on the next cycle; `ready_o` = 0.
  - After the mid-transfer reset: all outputs return to reset values immediately, without waiting for a clock edge.
- **Ideal far side, `SYNC_STAGES` = 2.** The bench raises `ack_i` 3 cycles after `req_o` rises and drops it 3 cycles after `req_o` falls. Required: `req_o` falls exactly 2 edges after `ack_i` is first sampled high; exactly one `done_o` pulse; `busy_o` low in the same cycle as `done_o`.
- **Backpressure.** Hold `valid_i` with `0x1` then `0x2` continuously across two transfers. Required: exactly two accepts; `data_o` sequence `0x1`, `0x2`; `data_o` never changes while `busy_o` = 1.
- **Stale ack.** Hold `ack_i` = 1 out of reset. Required: `ready_o` stays 0 and no accept occurs while `valid_i` = 1. Dropping `ack_i` makes `ready_o` = 1 after 2 edges.
- **Slow, jittered ack.** Randomized `ack_i` delays of 0–20 cycles over 100 transfers with random `data_i`. Required: the scoreboard sees every word exactly once and in order; `done_o` count = 100.
- **Two-phase build (`CDC_HS_SRC_TWO_PHASE_EN` defined).** Three transfers. Required: `req_o` sequence 1, 0, 1; each `done_o` follows 2 edges after `ack_i` first samples equal to `req_o`.
